// File: rtl/aludiv_ref_pkg.sv
// Shared types and helpers for the long-integer divider reference model.
package aludiv_ref_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int ERRW = 32;

    // Saturating add of a small increment to the error counter.
    function automatic logic [ERRW-1:0] sat_add(input logic [ERRW-1:0] v, input logic [1:0] n);
        logic [ERRW:0] s;
        s = {1'b0, v} + {{(ERRW-1){1'b0}}, n};
        return s[ERRW] ? '1 : s[ERRW-1:0];
    endfunction

endpackage

// File: rtl/aludiv_ref_step.sv
// One restoring-division step: compare the shifted partial remainder with
// the divisor and subtract when it fits.
module aludiv_ref_step #(
    parameter int DSW = 8192
) (
    input  logic [DSW:0]   i_t,
    input  logic [DSW-1:0] i_dvs,
    output logic [DSW:0]   o_rem,
    output logic           o_qbit
);

    // One extra bit beyond the DSW+1 operands exposes the borrow directly.
    logic [DSW+1:0] w_diff;

    // Trial subtraction; no borrow means t >= divisor.
    always_comb begin
        w_diff = {1'b0, i_t} - {2'b00, i_dvs};
        o_qbit = ~w_diff[DSW+1];
        o_rem  = o_qbit ? w_diff[DSW:0] : i_t;
    end

endmodule

// File: rtl/aludiv_ref.sv
// Cycle-based reference model of the long-integer divider: bit-serial
// restoring division, one quotient bit per clock, MSB first. Runs beside
// the RAM-based divider and counts protocol errors in errcnt.
module aludiv_ref
    import aludiv_ref_pkg::*;
#(
    parameter int DW  = 64,
    parameter int LW  = 16384,
    parameter int DEW = LW,
    parameter int DSW = LW / 2,
    parameter int CW  = $clog2(DEW) + 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           done,
    input  logic [DEW-1:0] de,
    input  logic [DSW-1:0] ds,
    output logic [LW-1:0]  qt,
    output logic [LW-1:0]  rm
);

    // DW only documents alignment with the companion divider's word size.
    localparam int DEW_WORDS = (DEW + DW - 1) / DW;

    state_t         r_state;
    logic [DEW-1:0] r_dvd;      // dividend, shifted out MSB first
    logic [DSW-1:0] r_dvs;
    logic [DSW-1:0] r_rem;      // partial remainder; always < divisor so DSW bits hold it
    logic [DEW-2:0] r_quo;      // quotient bits so far; the final bit joins at completion
    logic [CW-1:0]  r_cnt;
    logic           r_divz;     // captured divisor was zero
    logic [LW-1:0]  r_qt;
    logic [LW-1:0]  r_rm;
    logic [ERRW-1:0] errcnt;    // read hierarchically by the environment

    logic [DSW:0]   w_t;
    logic [DSW:0]   w_nrem;
    logic           w_qbit;
    logic [1:0]     w_inc;

    assign w_t = {r_rem, r_dvd[DEW-1]};
    assign qt  = r_qt;
    assign rm  = r_rm;

    aludiv_ref_step #(.DSW(DSW)) u_step (
        .i_t    (w_t),
        .i_dvs  (r_dvs),
        .o_rem  (w_nrem),
        .o_qbit (w_qbit)
    );

    // Error increments: early done and divide-by-zero; a start masks both.
    always_comb begin
        w_inc = '0;
        if (!start && r_state == ST_RUN)
            w_inc = {1'b0, done} + {1'b0, r_divz};
    end

    // Control FSM, shift registers, result registers and error counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_divz  <= 1'b0;
            r_qt    <= '0;
            r_rm    <= '0;
            errcnt  <= '0;
        end else begin
            errcnt <= sat_add(errcnt, w_inc);
            if (start) begin
                // A start while running abandons the old division; results hold.
                r_dvd   <= de;
                r_dvs   <= ds;
                r_rem   <= '0;
                r_quo   <= '0;
                r_cnt   <= CW'(DEW);
                r_divz  <= (ds == '0);
                r_state <= ST_RUN;
            end else if (r_state == ST_RUN) begin
                if (r_divz) begin
                    r_qt    <= LW'({DEW{1'b1}});
                    r_rm    <= LW'(r_dvd);
                    r_divz  <= 1'b0;
                    r_state <= ST_IDLE;
                end else begin
                    r_rem <= w_nrem[DSW-1:0];
                    r_quo <= {r_quo[DEW-3:0], w_qbit};
                    r_dvd <= {r_dvd[DEW-2:0], 1'b0};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_qt    <= LW'({r_quo, w_qbit});
                        r_rm    <= LW'(w_nrem);
                        r_state <= ST_IDLE;
                    end
                end
            end
        end
    end

    if (DEW_WORDS < 1) begin : g_bad_width
        // Unreachable for any legal parameter set; keeps DW tied into elaboration.
        logic w_unused;
        assign w_unused = 1'b0;
    end

endmodule

// File: tb/tb_aludiv_ref.sv
// Self-checking bench for aludiv_ref at LW=256.
module tb_aludiv_ref;

    localparam int LW  = 256;
    localparam int DEW = 256;
    localparam int DSW = 128;

    logic           clk = 1'b0;
    logic           resetn = 1'b1;
    logic           start = 1'b0;
    logic           done = 1'b0;
    logic [DEW-1:0] de = '0;
    logic [DSW-1:0] ds = '0;
    logic [LW-1:0]  qt;
    logic [LW-1:0]  rm;

    int errors = 0;
    int checks = 0;

    logic [LW-1:0] last_q = '0;
    logic [LW-1:0] last_r = '0;
    int unsigned   exp_err = 0;

    aludiv_ref #(.DW(64), .LW(LW), .DEW(DEW), .DSW(DSW), .CW(9)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .done   (done),
        .de     (de),
        .ds     (ds),
        .qt     (qt),
        .rm     (rm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns at the negedge just after the start edge.
    task automatic pulse_start(input logic [DEW-1:0] a, input logic [DSW-1:0] b, input logic d);
        @(negedge clk);
        de = a; ds = b; start = 1'b1; done = d;
        @(negedge clk);
        start = 1'b0; done = 1'b0;
    endtask

    // Wait n clocks and report whether qt/rm stayed at their last results.
    task automatic hold_wait(input int n, output logic ok);
        ok = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (qt !== last_q || rm !== last_r) ok = 1'b0;
        end
    endtask

    // Full division: results must hold for DEW-1 edges and appear on edge DEW.
    task automatic run_div(input string tag, input logic [DEW-1:0] a, input logic [DSW-1:0] b,
                           input logic [LW-1:0] eq, input logic [LW-1:0] er, input logic d);
        logic ok;
        pulse_start(a, b, d);
        hold_wait(DEW - 1, ok);
        check({tag, "_hold"}, {255'd0, ok}, {255'd0, 1'b1});
        @(negedge clk);
        check({tag, "_qt"}, qt, eq);
        check({tag, "_rm"}, rm, er);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        logic          ok;
        logic [DEW-1:0] a;
        logic [DSW-1:0] b;
        logic [LW-1:0]  mq;
        logic [LW-1:0]  mr;

        // Reset
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_qt", qt, '0);
        check("rst_rm", rm, '0);
        check("rst_err", LW'(dut.errcnt), '0);
        resetn = 1'b1;

        // Directed divisions
        run_div("basic", 256'd100, 128'd7, 256'd14, 256'd2, 1'b0);
        check("basic_err", LW'(dut.errcnt), LW'(exp_err));
        run_div("de_lt_ds", 256'd5, 128'd9, 256'd0, 256'd5, 1'b0);
        run_div("unit", 256'hDEADBEEF, 128'd1, 256'hDEADBEEF, 256'd0, 1'b0);
        a = '1; b = '1;
        mq = (256'd1 << 128) + 256'd1;
        run_div("max", a, b, mq, 256'd0, 1'b0);

        // done while idle is not an error
        @(negedge clk) done = 1'b1;
        @(negedge clk) done = 1'b0;
        check("idle_done_err", LW'(dut.errcnt), LW'(exp_err));

        // Divide by zero: result on the first edge after start
        pulse_start(256'd1234, 128'd0, 1'b0);
        @(negedge clk);
        exp_err++;
        last_q = '1;
        last_r = 256'd1234;
        check("dz_qt", qt, last_q);
        check("dz_rm", rm, last_r);
        check("dz_err", LW'(dut.errcnt), LW'(exp_err));

        // Restart mid-run: the first result must never appear
        pulse_start(256'd100, 128'd7, 1'b0);
        hold_wait(49, ok);
        check("restart_hold1", {255'd0, ok}, {255'd0, 1'b1});
        run_div("restart", 256'd77, 128'd10, 256'd7, 256'd7, 1'b0);
        check("restart_err", LW'(dut.errcnt), LW'(exp_err));

        // Early done during RUN
        pulse_start(256'd1000, 128'd3, 1'b0);
        repeat (10) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        exp_err++;
        check("early_done_err", LW'(dut.errcnt), LW'(exp_err));

        // Start and done together while running: start wins, no error
        run_div("start_done", 256'd77, 128'd10, 256'd7, 256'd7, 1'b1);
        check("start_done_err", LW'(dut.errcnt), LW'(exp_err));

        // Random operands against plain arithmetic
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 8; k++) a[k*32 +: 32] = $urandom;
            for (int k = 0; k < 4; k++) b[k*32 +: 32] = $urandom;
            a = a >> $urandom_range(0, 255);
            b = b >> $urandom_range(0, 127);
            if (b == '0) b = 128'd3;
            mq = a / {128'd0, b};
            mr = a % {128'd0, b};
            run_div($sformatf("rnd%0d", i), a, b, mq, mr, 1'b0);
        end
        check("rnd_err", LW'(dut.errcnt), LW'(exp_err));

        // Async reset during RUN clears everything at once
        pulse_start(256'd99999, 128'd13, 1'b0);
        repeat (30) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        exp_err = 0;
        last_q = '0;
        last_r = '0;
        check("arst_qt", qt, '0);
        check("arst_rm", rm, '0);
        check("arst_err", LW'(dut.errcnt), '0);
        @(negedge clk) resetn = 1'b1;
        hold_wait(300, ok);
        check("arst_hold", {255'd0, ok}, {255'd0, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
